// File: rtl/coeff_token_encoder.sv
// Two-stage pipelined CAVLC coeff_token encoder (H.264 Table 9-5) with running bit/token counters.
// Define CHROMA_DC_EN to add the chroma_dc input and the 4:2:0 chroma DC (nC=-1) table.
module coeff_token_encoder #(
    parameter int VAL_W = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       total_coeff,
    input  logic [1:0]       trailing_ones,
    input  logic [4:0]       nc,
`ifdef CHROMA_DC_EN
    input  logic             chroma_dc,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAL_W-1:0] code_val,
    output logic [LEN_W-1:0] code_len,
    output logic             err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] token_count
);

    typedef enum logic [2:0] {CLS_C0, CLS_C1, CLS_C2, CLS_FLC, CLS_CDC} cls_t;

    // Tables are indexed [TrailingOnes][TotalCoeff], one row per T1 value, so rows never alias.
    localparam logic [4:0] C0_LEN [4][17] = '{
        '{1, 6, 8, 9, 10, 11, 13, 13, 13, 14, 14, 15, 15, 16, 16, 16, 16},
        '{0, 2, 6, 8, 9, 10, 11, 13, 13, 14, 14, 15, 15, 15, 16, 16, 16},
        '{0, 0, 3, 7, 8, 9, 10, 11, 13, 13, 14, 14, 15, 15, 16, 16, 16},
        '{0, 0, 0, 5, 6, 7, 8, 9, 10, 11, 13, 14, 14, 15, 15, 16, 16}};
    localparam logic [3:0] C0_VAL [4][17] = '{
        '{1, 5, 7, 7, 7, 7, 15, 11, 8, 15, 11, 15, 11, 15, 11, 7, 4},
        '{0, 1, 4, 6, 6, 6, 6, 14, 10, 14, 10, 14, 10, 1, 14, 10, 6},
        '{0, 0, 1, 5, 5, 5, 5, 5, 13, 9, 13, 9, 13, 9, 13, 9, 5},
        '{0, 0, 0, 3, 3, 4, 4, 4, 4, 4, 12, 12, 8, 12, 8, 12, 8}};
    localparam logic [4:0] C1_LEN [4][17] = '{
        '{2, 6, 6, 7, 8, 8, 9, 11, 11, 12, 12, 12, 13, 13, 13, 14, 14},
        '{0, 2, 5, 6, 6, 7, 8, 9, 11, 11, 12, 12, 13, 13, 14, 14, 14},
        '{0, 0, 3, 6, 6, 7, 8, 9, 11, 11, 12, 12, 13, 13, 13, 14, 14},
        '{0, 0, 0, 4, 4, 5, 6, 6, 7, 9, 11, 11, 12, 13, 13, 13, 14}};
    localparam logic [3:0] C1_VAL [4][17] = '{
        '{3, 11, 7, 7, 7, 4, 7, 15, 11, 15, 11, 8, 15, 11, 7, 9, 7},
        '{0, 2, 7, 10, 6, 6, 6, 6, 14, 10, 14, 10, 14, 10, 11, 8, 6},
        '{0, 0, 3, 9, 5, 5, 5, 5, 13, 9, 13, 9, 13, 9, 6, 10, 5},
        '{0, 0, 0, 5, 4, 6, 8, 4, 4, 4, 12, 8, 12, 12, 8, 1, 4}};
    localparam logic [4:0] C2_LEN [4][17] = '{
        '{4, 6, 6, 6, 7, 7, 7, 7, 8, 8, 9, 9, 9, 10, 10, 10, 10},
        '{0, 4, 5, 5, 5, 5, 6, 6, 7, 8, 8, 9, 9, 9, 10, 10, 10},
        '{0, 0, 4, 5, 5, 5, 6, 6, 7, 7, 8, 8, 9, 9, 10, 10, 10},
        '{0, 0, 0, 4, 4, 4, 4, 4, 5, 6, 7, 8, 8, 9, 10, 10, 10}};
    localparam logic [3:0] C2_VAL [4][17] = '{
        '{15, 15, 11, 8, 15, 11, 9, 8, 15, 11, 15, 11, 8, 13, 9, 5, 1},
        '{0, 14, 15, 12, 10, 8, 14, 10, 14, 14, 10, 14, 10, 7, 12, 8, 4},
        '{0, 0, 13, 14, 11, 9, 13, 9, 13, 10, 13, 9, 13, 9, 11, 7, 3},
        '{0, 0, 0, 12, 11, 10, 9, 8, 13, 12, 12, 12, 8, 12, 10, 6, 2}};
`ifdef CHROMA_DC_EN
    localparam logic [4:0] CDC_LEN [4][5] = '{
        '{2, 6, 6, 6, 6}, '{0, 1, 6, 7, 8}, '{0, 0, 3, 7, 8}, '{0, 0, 0, 6, 7}};
    localparam logic [3:0] CDC_VAL [4][5] = '{
        '{1, 7, 4, 3, 2}, '{0, 1, 6, 3, 3}, '{0, 0, 1, 2, 2}, '{0, 0, 0, 5, 0}};
`endif

    cls_t             w_class;
    logic             w_illegal;
    logic [LEN_W-1:0] w_len;
    logic [VAL_W-1:0] w_val;
    logic             w_xfer;
    logic             w_s1_en;
    logic             w_s2_en;

    logic             r_s1_valid;
    cls_t             r_s1_class;
    logic [4:0]       r_s1_tc;
    logic [1:0]       r_s1_t1;
    logic             r_s1_illegal;

    assign w_xfer   = out_valid & out_ready;
    assign w_s2_en  = !out_valid | out_ready;
    assign w_s1_en  = !r_s1_valid | w_s2_en;
    assign in_ready = w_s1_en;

    always_comb begin
        w_class = CLS_FLC;
        if (nc < 5'd2)
            w_class = CLS_C0;
        else if (nc < 5'd4)
            w_class = CLS_C1;
        else if (nc < 5'd8)
            w_class = CLS_C2;
`ifdef CHROMA_DC_EN
        if (chroma_dc)
            w_class = CLS_CDC;
`endif
    end

    always_comb begin
        w_illegal = ({3'b000, trailing_ones} > total_coeff) || (total_coeff > 5'd16);
`ifdef CHROMA_DC_EN
        if (chroma_dc && (total_coeff > 5'd4))
            w_illegal = 1'b1;
`endif
    end

    // Illegal requests fall through with zero code and zero length.
    always_comb begin
        w_len = '0;
        w_val = '0;
        if (!r_s1_illegal) begin
            case (r_s1_class)
                CLS_C0: begin
                    w_len = LEN_W'(C0_LEN[r_s1_t1][r_s1_tc]);
                    w_val = VAL_W'(C0_VAL[r_s1_t1][r_s1_tc]);
                end
                CLS_C1: begin
                    w_len = LEN_W'(C1_LEN[r_s1_t1][r_s1_tc]);
                    w_val = VAL_W'(C1_VAL[r_s1_t1][r_s1_tc]);
                end
                CLS_C2: begin
                    w_len = LEN_W'(C2_LEN[r_s1_t1][r_s1_tc]);
                    w_val = VAL_W'(C2_VAL[r_s1_t1][r_s1_tc]);
                end
                CLS_FLC: begin
                    w_len = LEN_W'(6);
                    w_val = (r_s1_tc == 5'd0) ? VAL_W'(3) : VAL_W'({r_s1_tc - 5'd1, r_s1_t1});
                end
`ifdef CHROMA_DC_EN
                CLS_CDC: begin
                    w_len = LEN_W'(CDC_LEN[r_s1_t1][r_s1_tc[2:0]]);
                    w_val = VAL_W'(CDC_VAL[r_s1_t1][r_s1_tc[2:0]]);
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_class   <= CLS_C0;
            r_s1_tc      <= '0;
            r_s1_t1      <= '0;
            r_s1_illegal <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_class   <= w_class;
                r_s1_tc      <= total_coeff;
                r_s1_t1      <= trailing_ones;
                r_s1_illegal <= w_illegal;
            end
        end
    end

    // S2 only moves when the consumer takes the current result, so a stall freezes the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            code_val  <= '0;
            code_len  <= '0;
            err       <= 1'b0;
        end else if (w_s2_en) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                code_val <= w_val;
                code_len <= w_len;
                err      <= r_s1_illegal;
            end
        end
    end

    // A clear that coincides with a transfer keeps that transfer's contribution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_count   <= '0;
            token_count <= '0;
        end else if (cnt_clr) begin
            bit_count   <= w_xfer ? CNT_W'(code_len) : '0;
            token_count <= w_xfer ? CNT_W'(1) : '0;
        end else if (w_xfer) begin
            bit_count   <= bit_count + CNT_W'(code_len);
            token_count <= token_count + CNT_W'(1);
        end
    end

endmodule
